ecc_write_encoder: RTL
======================

// Module: ecc_write_encoder
// PURPOSE
//  Write-path ECC encoder feeding the 72-bit ECC decoder stage.
//  - Takes 64-bit data words on a valid/ready stream and appends the 8-bit check field.
//  - Check field: {7'b0, ^data[63:0]}, the field layout the decoder compares against data[71:64].
//  - Buffers words in a 2-entry skid, so throughput is full and in_ready is registered.
//  - Provides one-shot bit-flip error injection and an output word counter for decoder bring-up.
// PARAMETERS
//  DATA_W   64  payload width; codeword is DATA_W+CHECK_W
//  CHECK_W   8  check field width; bits [CHECK_W-1:1] of the field are always 0
//  CNT_W    32  width of word_count
// PORTS
//  sys_clk     in   1              single clock, all logic rising-edge
//  sys_rst_n   in   1              synchronous reset, active-low
//  in_valid    in   1              upstream word valid
//  in_ready    out  1              encoder can accept (registered)
//  in_data     in   DATA_W         payload
//  out_valid   out  1              codeword valid
//  out_ready   in   1              downstream accepts
//  out_data    out  DATA_W+CHECK_W {check, payload}; check in [71:64]
//  inj_arm     in   1              pulse: corrupt next accepted word
//  inj_bit     in   7              codeword bit index to flip (0..71)
//  inj_done    out  1              1-cycle pulse when the armed word is accepted
//  word_count  out  CNT_W          count of output handshakes
// BEHAVIOUR
//  - Reset (sys_rst_n=0 at an edge): in_ready=0, out_valid=0, out_data=0, inj_done=0,
//    word_count=0, armed=0, skid empty.
//    First cycle after reset release: in_ready=1. Reset mid-stream drops all buffered words.
//  - Accept when in_valid&&in_ready; emit when out_valid&&out_ready.
//  - Codeword per accepted word: cw = {{7'b0,^in_data}, in_data}. If armed, cw ^= (1<<inj_bit).
//  - Latency: word accepted at edge N is presented on out_data after edge N (out_valid=1 in cycle N+1).
//  - Buffer states:
//    EMPTY : out_valid=0, in_ready=1. Accept -> ONE.
//    ONE   : out_valid=1, in_ready=1.
//            accept & emit -> ONE, output reg reloaded with the new word.
//            accept only   -> TWO, new word into skid.
//            emit only     -> EMPTY.
//    TWO   : out_valid=1, in_ready=0.
//            emit -> ONE, skid moves to the output register.
//            no emit -> hold.
//  - Order is strictly preserved. out_data is stable while out_valid&&!out_ready.
//  - No combinational path from out_ready to in_ready.
//  - Injection:
//    inj_arm sets armed. Arm while already armed is ignored (the first inj_bit is kept).
//    inj_bit is sampled on the arm cycle and held in a register.
//    Arm in the same cycle as an accept applies to the NEXT accepted word, not the current one.
//    On the first accept while armed: flip applied, armed cleared, inj_done=1 for the following cycle.
//    inj_bit>=72: no flip, but arm is still consumed and inj_done still pulses.
//  - word_count increments on each output handshake and wraps 2^CNT_W-1 -> 0.
// TESTING
//  1. Reset then in_data=64'h0000_0000_0000_0001 with out_ready=1
//     -> next cycle out_data=72'h01_0000_0000_0000_0001, word_count 0->1.
//  2. in_data=64'hFFFF_FFFF_FFFF_FFFF -> out_data=72'h00_FFFF_FFFF_FFFF_FFFF.
//     Feed 100 back-to-back words with out_ready=1 -> 100 outputs, in_ready constantly 1.
//  3. out_ready=0, send words A,B,C
//     -> A,B accepted, in_ready=0 from the cycle after B, C stalled.
//     out_ready=1 -> outputs A,B,C in order, count=3.
//  4. inj_arm with inj_bit=5, then send 64'h0
//     -> out_data=72'h00_0000_0000_0000_0020, inj_done pulses once.
//     Next word is unflipped.
//  5. inj_arm with inj_bit=64 in the same cycle as an accept of 64'h3
//     -> that word is clean (check=0), next word 64'h0 -> out_data=72'h01_..._00.
//  6. Reset asserted while in state TWO -> out_valid=0, word_count=0 next cycle; no stale word emitted.

Source files
------------

// File: rtl/ecc_write_encoder.sv
// Write-path ECC encoder: appends a parity check field to each 64-bit word, buffers through a
// 2-entry skid so in_ready can be registered, and supports one-shot bit-flip injection.
module ecc_write_encoder #(
    parameter int DATA_W  = 64,
    parameter int CHECK_W = 8,
    parameter int CNT_W   = 32
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W+CHECK_W-1:0] out_data,
    input  logic                      inj_arm,
    input  logic [6:0]                inj_bit,
    output logic                      inj_done,
    output logic [CNT_W-1:0]          word_count
);
    localparam int CW_W = DATA_W + CHECK_W;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t          state, state_n;
    logic [CW_W-1:0] skid_q;
    logic [CW_W-1:0] cw;
    logic [CW_W-1:0] flip_mask;
    logic            armed;
    logic [6:0]      inj_bit_q;
    logic            accept, emit;
    logic            load_out, load_skid, skid_to_out;

    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && in_ready;
    assign emit      = out_valid && out_ready;

    // Out-of-range bit index yields an empty mask: the arm is still consumed, nothing flips.
    always_comb begin
        flip_mask = '0;
        if (int'(inj_bit_q) < CW_W)
            flip_mask = {{(CW_W-1){1'b0}}, 1'b1} << inj_bit_q;
        cw = {{(CHECK_W-1){1'b0}}, ^in_data, in_data} ^ (armed ? flip_mask : '0);
    end

    always_comb begin
        state_n     = state;
        load_out    = 1'b0;
        load_skid   = 1'b0;
        skid_to_out = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_n  = ONE;
                    load_out = 1'b1;
                end
            end
            ONE: begin
                if (accept && emit) begin
                    load_out = 1'b1;
                end else if (accept) begin
                    state_n   = TWO;
                    load_skid = 1'b1;
                end else if (emit) begin
                    state_n = EMPTY;
                end
            end
            TWO: begin
                if (emit) begin
                    state_n     = ONE;
                    skid_to_out = 1'b1;
                end
            end
            default: state_n = EMPTY;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state      <= EMPTY;
            in_ready   <= 1'b0;
            out_data   <= '0;
            skid_q     <= '0;
            armed      <= 1'b0;
            inj_bit_q  <= '0;
            inj_done   <= 1'b0;
            word_count <= '0;
        end else begin
            state    <= state_n;
            // Derived from next state only, so out_ready never reaches in_ready combinationally.
            in_ready <= (state_n != TWO);
            if (load_out)
                out_data <= cw;
            else if (skid_to_out)
                out_data <= skid_q;
            if (load_skid)
                skid_q <= cw;
            if (emit)
                word_count <= word_count + 1'b1;

            // An arm seen alongside an accept targets the following word.
            inj_done <= accept && armed;
            if (accept && armed) begin
                armed <= 1'b0;
            end else if (inj_arm && !armed) begin
                armed     <= 1'b1;
                inj_bit_q <= inj_bit;
            end
        end
    end
endmodule
